// File: rtl/lfsr_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr_share_arbiter                                           |
// | Description : Shares a free-running 10-bit LFSR stream among NUM_REQ       |
// |               requesters. Requesters are served round-robin. Each grant    |
// |               delivers one bounded value in [0, LIMIT), obtained by        |
// |               rejection sampling of the LFSR low bits. After MAX_TRIES     |
// |               rejected samples a fallback value of 0 is delivered and      |
// |               flagged with timeout.                                        |
// | Ports       : clk       - system clock                                     |
// |               reset     - synchronous, active-high reset                   |
// |               lfsr_in   - LFSR output, advancing every clock               |
// |               req       - per-requester level request                      |
// |               ack       - one-hot, one-cycle pulse to served requester     |
// |               rnd_out   - delivered value, valid while rnd_valid=1         |
// |               rnd_valid - high for exactly the ack cycle                   |
// |               timeout   - high with rnd_valid when fallback was delivered  |
// |               busy      - high while sampling for a winner                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lfsr_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int OUT_W     = 4,
  parameter int LIMIT     = 10,
  parameter int MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         lfsr_in,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [OUT_W-1:0]   rnd_out,
  output logic               rnd_valid,
  output logic               timeout,
  output logic               busy
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

  // Candidate and bound compared at 11 bits so LIMIT = 2^10 is representable.
  localparam logic [10:0]        c_LIMIT    = 11'(LIMIT);
  localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_REQ = c_PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SAMPLE = 1'b1
  } state_t;

  // Registered state and outputs
  state_t               r_state;
  logic [c_PTR_W-1:0]   r_winner;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_TRY_W-1:0]   r_tries;
  logic [NUM_REQ-1:0]   r_ack;
  logic [OUT_W-1:0]     r_rnd_out;
  logic                 r_rnd_valid;
  logic                 r_timeout;
  logic                 r_busy;

  // Next-state values
  state_t               w_state;
  logic [c_PTR_W-1:0]   w_winner;
  logic [c_PTR_W-1:0]   w_rr_ptr;
  logic [c_TRY_W-1:0]   w_tries;
  logic [NUM_REQ-1:0]   w_ack;
  logic [OUT_W-1:0]     w_rnd_out;
  logic                 w_rnd_valid;
  logic                 w_timeout;
  logic                 w_busy;

  // Arbitration helpers
  logic [NUM_REQ-1:0]   w_eff;
  logic                 w_found;
  logic [c_PTR_W-1:0]   w_pick;
  int                   w_idx;

  // Sampling helpers
  logic [OUT_W-1:0]     w_cand;
  logic [10:0]          w_cand_ext;
  logic [c_PTR_W-1:0]   w_next_ptr;
  logic                 w_unused;

  assign w_cand     = lfsr_in[OUT_W-1:0];
  assign w_cand_ext = {{(11 - OUT_W){1'b0}}, w_cand};
  // Upper LFSR bits are intentionally ignored when OUT_W < 10.
  assign w_unused   = ^lfsr_in;

  // Pointer following the winner, wrapping for non-power-of-two NUM_REQ.
  assign w_next_ptr = (r_winner == c_LAST_REQ) ? '0 : r_winner + 1'b1;

  // Round-robin search: first set bit of eff starting at rr_ptr, wrapping.
  // The requester being acked this cycle is masked so that a held req does
  // not win again immediately; it is re-arbitrated from the next cycle.
  always_comb begin
    w_eff   = req & ~r_ack;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && w_eff[w_idx[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[c_PTR_W-1:0];
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_winner    <= '0;
      r_rr_ptr    <= '0;
      r_tries     <= '0;
      r_ack       <= '0;
      r_rnd_out   <= '0;
      r_rnd_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_winner    <= w_winner;
      r_rr_ptr    <= w_rr_ptr;
      r_tries     <= w_tries;
      r_ack       <= w_ack;
      r_rnd_out   <= w_rnd_out;
      r_rnd_valid <= w_rnd_valid;
      r_timeout   <= w_timeout;
      r_busy      <= w_busy;
    end
  end

  // Next-state and next-output logic. Output pulses default to zero so each
  // delivery lasts exactly one cycle.
  always_comb begin
    w_state     = r_state;
    w_winner    = r_winner;
    w_rr_ptr    = r_rr_ptr;
    w_tries     = r_tries;
    w_ack       = '0;
    w_rnd_out   = '0;
    w_rnd_valid = 1'b0;
    w_timeout   = 1'b0;
    w_busy      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state  = S_SAMPLE;
          w_winner = w_pick;
          w_tries  = '0;
          w_busy   = 1'b1;
        end
      end

      S_SAMPLE: begin
        if (!req[r_winner]) begin
          // Abandoned: no delivery, pointer left where it was.
          w_state = S_IDLE;
        end else if (w_cand_ext < c_LIMIT) begin
          w_ack[r_winner] = 1'b1;
          w_rnd_out       = w_cand;
          w_rnd_valid     = 1'b1;
          w_rr_ptr        = w_next_ptr;
          w_state         = S_IDLE;
        end else if (r_tries == c_LAST_TRY) begin
          // Out of retries: deliver the fallback value 0.
          w_ack[r_winner] = 1'b1;
          w_rnd_valid     = 1'b1;
          w_timeout       = 1'b1;
          w_rr_ptr        = w_next_ptr;
          w_state         = S_IDLE;
        end else begin
          w_tries = r_tries + 1'b1;
          w_busy  = 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign ack       = r_ack;
  assign rnd_out   = r_rnd_out;
  assign rnd_valid = r_rnd_valid;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lfsr_share_arbiter                                        |
// | Description : Self-checking bench for lfsr_share_arbiter. Directed vector  |
// |               table, hand-written corner sequences and a randomized phase, |
// |               all checked against a transaction-level reference model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lfsr_share_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int OUT_W     = 4;
  localparam int LIMIT     = 10;
  localparam int MAX_TRIES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] lfsr_in;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] rnd_out;
  logic       rnd_valid;
  logic       timeout;
  logic       busy;

  lfsr_share_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .OUT_W    (OUT_W),
    .LIMIT    (LIMIT),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lfsr_in  (lfsr_in),
    .req      (req),
    .ack      (ack),
    .rnd_out  (rnd_out),
    .rnd_valid(rnd_valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_serving: requester currently being sampled for, or -1 when none.
  int         m_serving = -1;
  int         m_samples = 0;
  int         m_ptr     = 0;
  logic [3:0] m_prev_ack = '0;
  logic [3:0] e_ack;
  logic [3:0] e_out;
  logic       e_vld;
  logic       e_to;
  logic       e_busy;

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic [9:0] lf);
    logic [3:0] eff;
    int         cand;
    bit         found;
    e_ack = '0; e_out = '0; e_vld = 1'b0; e_to = 1'b0;
    if (r) begin
      m_serving = -1; m_samples = 0; m_ptr = 0;
    end else if (m_serving < 0) begin
      eff   = rq & ~m_prev_ack;
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && eff[(m_ptr + k) % NUM_REQ]) begin
          found     = 1;
          m_serving = (m_ptr + k) % NUM_REQ;
          m_samples = 0;
        end
      end
    end else if (!rq[m_serving]) begin
      m_serving = -1;
    end else begin
      cand = int'(lf) % (1 << OUT_W);
      m_samples++;
      if (cand < LIMIT || m_samples == MAX_TRIES) begin
        e_ack[m_serving] = 1'b1;
        e_vld = 1'b1;
        e_to  = !(cand < LIMIT);
        e_out = e_to ? 4'd0 : 4'(cand);
        m_ptr = (m_serving + 1) % NUM_REQ;
        m_serving = -1;
      end
    end
    e_busy     = (m_serving >= 0);
    m_prev_ack = e_ack;
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [9:0] lf);
    reset = r; req = rq; lfsr_in = lf;
    @(posedge clk);
    model_edge(r, rq, lf);
    #1;
    chk("m_ack", ack, e_ack);
    chk("m_valid", rnd_valid, e_vld);
    chk("m_timeout", timeout, e_to);
    chk("m_busy", busy, e_busy);
    if (e_vld) chk("m_rnd_out", rnd_out, e_out);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [9:0] lf;
    logic [3:0] ack;
    logic       vld;
    logic [3:0] dout;
    logic       to;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [9:0] lf,
                     input logic [3:0] a, input logic v, input logic [3:0] d,
                     input logic t, input logic b);
    vec_t x;
    x.rst = r; x.rq = rq; x.lf = lf; x.ack = a; x.vld = v; x.dout = d; x.to = t; x.busy = b;
    tbl.push_back(x);
  endtask

  logic [3:0] rq_r;
  logic [9:0] lf_r;

  initial begin
    reset = 1'b1; req = '0; lfsr_in = '0;

    // reset state
    add(1, 4'h0, 10'h000, 4'h0, 0, 4'h0, 0, 0);
    add(1, 4'h0, 10'h3FF, 4'h0, 0, 4'h0, 0, 0);
    // single requester, sample 3 accepted, ack two cycles after req
    add(0, 4'h1, 10'h3F5, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'h1, 10'h2A3, 4'h1, 1, 4'h3, 0, 0);
    add(0, 4'h0, 10'h000, 4'h0, 0, 4'h0, 0, 0);
    // reset then all four held: round-robin acks two cycles apart
    add(1, 4'h0, 10'h000, 4'h0, 0, 4'h0, 0, 0);
    add(0, 4'hF, 10'h105, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'hF, 10'h105, 4'h1, 1, 4'h5, 0, 0);
    add(0, 4'hF, 10'h201, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'hF, 10'h201, 4'h2, 1, 4'h1, 0, 0);
    add(0, 4'hF, 10'h309, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'hF, 10'h309, 4'h4, 1, 4'h9, 0, 0);
    add(0, 4'hF, 10'h000, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'hF, 10'h000, 4'h8, 1, 4'h0, 0, 0);
    add(0, 4'hF, 10'h0F8, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'hF, 10'h0F8, 4'h1, 1, 4'h8, 0, 0);
    add(0, 4'h0, 10'h000, 4'h0, 0, 4'h0, 0, 0);
    // requester 1: samples 12, 15 rejected, 7 accepted; busy for 3 cycles
    add(0, 4'h2, 10'h111, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'h2, 10'h3AC, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'h2, 10'h2BF, 4'h0, 0, 4'h0, 0, 1);
    add(0, 4'h2, 10'h1C7, 4'h2, 1, 4'h7, 0, 0);
    add(0, 4'h0, 10'h000, 4'h0, 0, 4'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].rq, tbl[i].lf);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i), rnd_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].to);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      if (tbl[i].vld) chk($sformatf("tbl%0d_rnd_out", i), rnd_out, tbl[i].dout);
    end

    // ---- all samples rejected: fallback after MAX_TRIES samples ----
    cycle(0, 4'h1, 10'h2A2);
    chk("to_busy0", busy, 1);
    for (int i = 0; i < MAX_TRIES; i++) begin
      cycle(0, 4'h1, {6'($urandom), 4'(10 + $urandom_range(0, 5))});
      if (i < MAX_TRIES - 1) begin
        chk("to_wait_ack", ack, 4'h0);
        chk("to_wait_busy", busy, 1);
      end
    end
    chk("to_ack", ack, 4'h1);
    chk("to_valid", rnd_valid, 1);
    chk("to_timeout", timeout, 1);
    chk("to_rnd_out", rnd_out, 4'h0);
    cycle(0, 4'h0, 10'h000);

    // ---- abandon mid-sample, then a different requester is served ----
    cycle(0, 4'h4, 10'h033);
    cycle(0, 4'h4, 10'h1EE);
    chk("ab_busy_rej", busy, 1);
    cycle(0, 4'h0, 10'h002);
    chk("ab_ack", ack, 4'h0);
    chk("ab_busy", busy, 0);
    chk("ab_valid", rnd_valid, 0);
    cycle(0, 4'h8, 10'h000);
    cycle(0, 4'h8, 10'h2F2);
    chk("ab_next_ack", ack, 4'h8);
    chk("ab_next_out", rnd_out, 4'h2);
    cycle(0, 4'h0, 10'h000);

    // ---- reset in the 2nd sample cycle, held request served fresh ----
    cycle(0, 4'h6, 10'h000);
    cycle(0, 4'h6, 10'h0AD);
    cycle(1, 4'h6, 10'h004);
    chk("rst_ack", ack, 4'h0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_timeout", timeout, 0);
    cycle(0, 4'h6, 10'h3FF);
    chk("rst_rearb_busy", busy, 1);
    cycle(0, 4'h6, 10'h306);
    chk("rst_served_ack", ack, 4'h2);
    chk("rst_served_out", rnd_out, 4'h6);
    cycle(0, 4'h0, 10'h000);

    // ---- randomized phase against the model ----
    rq_r = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(0, 5) == 0) rq_r[b] = ~rq_r[b];
      end
      lf_r = 10'($urandom);
      cycle(($urandom_range(0, 99) == 0), rq_r, lf_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
